// File: rtl/maze_pkg.sv
// Shared arena geometry, key bit positions and move FSM encoding
// for the maze player controller and its helpers.
package maze_pkg;

    localparam int ARENA_W   = 700;
    localparam int ARENA_H   = 500;
    localparam int OBST_SIDE = 100;
    localparam int COORD_W   = 12;

    localparam int KEY_UP    = 3;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_LEFT  = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } move_state_e;

endpackage

// File: rtl/rect_overlap.sv
// Combinational test of two axis-aligned squares for strict overlap;
// shared edges or corners do not count as overlap.
module rect_overlap #(
    parameter int A_SIZE = 20,
    parameter int B_SIZE = 100
) (
    input  logic [11:0] ax_i,
    input  logic [11:0] ay_i,
    input  logic [11:0] bx_i,
    input  logic [11:0] by_i,
    output logic        overlap_o
);

    localparam logic [12:0] A_SIZE13 = 13'(A_SIZE);
    localparam logic [12:0] B_SIZE13 = 13'(B_SIZE);

    logic [12:0] ax13;
    logic [12:0] ay13;
    logic [12:0] bx13;
    logic [12:0] by13;

    // One extra bit keeps corner + size from wrapping near the 12-bit limit.
    assign ax13 = {1'b0, ax_i};
    assign ay13 = {1'b0, ay_i};
    assign bx13 = {1'b0, bx_i};
    assign by13 = {1'b0, by_i};

    assign overlap_o = (ax13 < bx13 + B_SIZE13) &&
                       (bx13 < ax13 + A_SIZE13) &&
                       (ay13 < by13 + B_SIZE13) &&
                       (by13 < ay13 + A_SIZE13);

endmodule

// File: rtl/player_move_ctl.sv
// Player movement controller: rate-limited key moves, clamped to the arena,
// with a one-obstacle-per-cycle collision scan before a move is committed.
module player_move_ctl #(
    parameter int ARENA_W     = maze_pkg::ARENA_W,
    parameter int ARENA_H     = maze_pkg::ARENA_H,
    parameter int PLAYER_SIZE = 20,
    parameter int OBST_SIDE   = maze_pkg::OBST_SIDE,
    parameter int N_OBST      = 3,
    parameter int STEP        = 1,
    parameter int MOVE_DIV    = 65536,
    parameter int START_X     = 0,
    parameter int START_Y     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            keys,
    input  logic                  restart,
    input  logic [24*N_OBST-1:0]  obst_xy,
    output logic [11:0]           xpos,
    output logic [11:0]           ypos,
    output logic                  moved,
    output logic                  blocked,
    output logic                  busy
);

    import maze_pkg::*;

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int IDX_W = (N_OBST > 1) ? $clog2(N_OBST) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OBST - 1);
    localparam logic [12:0]      STEP13   = 13'(STEP);
    localparam logic [12:0]      XMAX13   = 13'(ARENA_W - PLAYER_SIZE);
    localparam logic [12:0]      YMAX13   = 13'(ARENA_H - PLAYER_SIZE);
    localparam logic [11:0]      XSTART   = 12'(START_X);
    localparam logic [11:0]      YSTART   = 12'(START_Y);

    move_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [11:0]      xpos_q;
    logic [11:0]      ypos_q;
    logic [11:0]      candX_q;
    logic [11:0]      candY_q;
    logic [11:0]      candX_d;
    logic [11:0]      candY_d;
    logic             moved_q;
    logic             blocked_q;
    logic             busy_q;

    logic             tick;
    logic             noMove;
    logic             hit;
    logic [11:0]      obstX;
    logic [11:0]      obstY;
    logic [12:0]      x13;
    logic [12:0]      y13;
    logic [12:0]      incX;
    logic [12:0]      incY;
    logic [12:0]      decX;
    logic [12:0]      decY;

    // Move-rate divider: free-running, tick on the final count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    assign x13  = {1'b0, xpos_q};
    assign y13  = {1'b0, ypos_q};
    assign incX = x13 + STEP13;
    assign incY = y13 + STEP13;
    assign decX = x13 - STEP13;
    assign decY = y13 - STEP13;

    // Candidate for the highest-priority pressed key, clamped to the arena.
    always_comb begin
        candX_d = xpos_q;
        candY_d = ypos_q;
        if (keys[KEY_UP]) begin
            candY_d = (y13 < STEP13) ? 12'd0 : 12'(decY);
        end else if (keys[KEY_DOWN]) begin
            candY_d = (incY > YMAX13) ? 12'(YMAX13) : 12'(incY);
        end else if (keys[KEY_RIGHT]) begin
            candX_d = (incX > XMAX13) ? 12'(XMAX13) : 12'(incX);
        end else if (keys[KEY_LEFT]) begin
            candX_d = (x13 < STEP13) ? 12'd0 : 12'(decX);
        end
    end

    assign noMove = (candX_d == xpos_q) && (candY_d == ypos_q);

    always_comb begin
        obstX = '0;
        obstY = '0;
        for (int i = 0; i < N_OBST; i++) begin
            if (idx_q == IDX_W'(i)) begin
                obstX = obst_xy[24*i+12 +: 12];
                obstY = obst_xy[24*i +: 12];
            end
        end
    end

    rect_overlap #(
        .A_SIZE (PLAYER_SIZE),
        .B_SIZE (OBST_SIDE)
    ) u_overlap (
        .ax_i      (candX_q),
        .ay_i      (candY_q),
        .bx_i      (obstX),
        .by_i      (obstY),
        .overlap_o (hit)
    );

    // Restart outranks everything, so a commit in the same cycle is dropped silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            xpos_q    <= XSTART;
            ypos_q    <= YSTART;
            candX_q   <= XSTART;
            candY_q   <= YSTART;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            if (restart) begin
                state_q <= ST_IDLE;
                idx_q   <= '0;
                xpos_q  <= XSTART;
                ypos_q  <= YSTART;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (tick && (keys != 4'b0000)) begin
                            if (noMove) begin
                                blocked_q <= 1'b1;
                            end else begin
                                candX_q <= candX_d;
                                candY_q <= candY_d;
                                idx_q   <= '0;
                                state_q <= ST_CHECK;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (hit) begin
                            blocked_q <= 1'b1;
                            idx_q     <= '0;
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                        end else if (idx_q == IDX_LAST) begin
                            xpos_q  <= candX_q;
                            ypos_q  <= candY_q;
                            moved_q <= 1'b1;
                            idx_q   <= '0;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;
    assign busy    = busy_q;

endmodule
